// File: rtl/sdram_init_refresh_arbiter.sv
// SDRAM command-bus owner for the DE10-Lite board: runs the power-up
// initialisation sequence, then issues periodic AUTO REFRESH. It also lends
// the command bus to a single user engine through a request/grant handshake.
// Pending refreshes are always served before a new grant is given.
module sdram_init_refresh_arbiter #(
  parameter int          INIT_WAIT        = 5000,
  parameter int          T_RP             = 1,
  parameter int          T_RC             = 4,
  parameter int          T_MRD            = 2,
  parameter int          INIT_REFRESHES   = 8,
  parameter int          REFRESH_INTERVAL = 390,
  parameter int          MAX_POSTPONE     = 8,
  parameter logic [12:0] MODE_REG         = 13'h0020
) (
  input  logic        MAX10_CLK1_50,
  input  logic        RESET_N,
  input  logic        usr_req,
  input  logic [3:0]  usr_cmd,
  input  logic [1:0]  usr_ba,
  input  logic [12:0] usr_addr,
  output logic        usr_gnt,
  output logic        ref_urgent,
  output logic        init_done,
  output logic        ref_overflow,
  output logic        DRAM_CKE,
  output logic        DRAM_CS_N,
  output logic        DRAM_RAS_N,
  output logic        DRAM_CAS_N,
  output logic        DRAM_WE_N,
  output logic [1:0]  DRAM_BA,
  output logic [12:0] DRAM_ADDR
);

  localparam logic [2:0] S_WAIT  = 3'd0;
  localparam logic [2:0] S_PRE   = 3'd1;
  localparam logic [2:0] S_REF   = 3'd2;
  localparam logic [2:0] S_MRS   = 3'd3;
  localparam logic [2:0] S_IDLE  = 3'd4;
  localparam logic [2:0] S_GRANT = 3'd5;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_REF = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;
  localparam logic [3:0] CMD_INH = 4'b1111;

  localparam int CNT_W = $clog2(INIT_WAIT + T_RP + T_RC + T_MRD + 1);
  localparam int TMR_W = $clog2(REFRESH_INTERVAL + 1);
  localparam int PND_W = $clog2(MAX_POSTPONE + 1);
  localparam int IRF_W = $clog2(INIT_REFRESHES + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(INIT_WAIT - 1);
  localparam logic [CNT_W-1:0] RP_LAST   = CNT_W'(T_RP);
  localparam logic [CNT_W-1:0] RC_LAST   = CNT_W'(T_RC);
  localparam logic [CNT_W-1:0] MRD_LAST  = CNT_W'(T_MRD);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [PND_W-1:0] PND_MAX   = PND_W'(MAX_POSTPONE);
  localparam logic [IRF_W-1:0] IRF_LAST  = IRF_W'(INIT_REFRESHES - 1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;        // cycle index inside the current command slot
  logic [IRF_W-1:0] init_refs;  // init refreshes completed so far
  logic [TMR_W-1:0] timer;
  logic [PND_W-1:0] pending;
  logic [PND_W-1:0] pend_nxt;
  logic [3:0]       dram_cmd;
  logic             tick;
  logic             rt_issue;
  logic             ovf_set;

  assign {DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N} = dram_cmd;

  // A runtime refresh is issued on the first cycle of a post-init S_REF slot.
  assign tick     = init_done && (timer == TMR_LAST);
  assign rt_issue = init_done && (state == S_REF) && (cnt == '0);

  // Next pending-refresh count: a tick adds one, an issue removes one, both cancel.
  always_comb begin
    pend_nxt = pending;
    ovf_set  = 1'b0;
    if (tick && !rt_issue) begin
      if (pending == PND_MAX) ovf_set  = 1'b1;
      else                    pend_nxt = pending + PND_W'(1);
    end else if (!tick && rt_issue) begin
      pend_nxt = pending - PND_W'(1);
    end
  end

  // Refresh interval timer, pending counter and sticky overflow flag.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      timer        <= '0;
      pending      <= '0;
      ref_overflow <= 1'b0;
    end else begin
      if (init_done) timer <= tick ? '0 : timer + TMR_W'(1);
      pending <= pend_nxt;
      if (ovf_set) ref_overflow <= 1'b1;
    end
  end

  // Main sequencer: init sequence, refresh slots, grant handling and registered pins.
  always_ff @(posedge MAX10_CLK1_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state      <= S_WAIT;
      cnt        <= '0;
      init_refs  <= '0;
      usr_gnt    <= 1'b0;
      ref_urgent <= 1'b0;
      init_done  <= 1'b0;
      DRAM_CKE   <= 1'b0;
      dram_cmd   <= CMD_INH;
      DRAM_BA    <= '0;
      DRAM_ADDR  <= '0;
    end else begin
      DRAM_CKE  <= 1'b1;
      dram_cmd  <= CMD_NOP;
      DRAM_BA   <= '0;
      DRAM_ADDR <= '0;
      case (state)
        S_WAIT: begin
          if (cnt == WAIT_LAST) begin
            state <= S_PRE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_PRE: begin
          if (cnt == '0) begin
            dram_cmd  <= CMD_PRE;
            DRAM_ADDR <= 13'h0400;  // A10 high: precharge all banks
          end
          if (cnt == RP_LAST) begin
            state <= S_REF;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_REF: begin
          if (cnt == '0) dram_cmd <= CMD_REF;
          if (cnt == RC_LAST) begin
            cnt <= '0;
            if (init_done) begin
              state <= (pend_nxt != '0) ? S_REF : S_IDLE;
            end else if (init_refs == IRF_LAST) begin
              state <= S_MRS;
            end else begin
              init_refs <= init_refs + IRF_W'(1);
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_MRS: begin
          if (cnt == '0) begin
            dram_cmd  <= CMD_LMR;
            DRAM_ADDR <= MODE_REG;
          end
          if (cnt == MRD_LAST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_IDLE: begin
          if (pending != '0) begin
            state <= S_REF;
            cnt   <= '0;
          end else if (usr_req) begin
            state      <= S_GRANT;
            usr_gnt    <= 1'b1;
            ref_urgent <= (pend_nxt != '0);
          end
        end
        S_GRANT: begin
          if (!usr_req) begin
            state      <= S_IDLE;
            usr_gnt    <= 1'b0;
            ref_urgent <= 1'b0;
          end else begin
            dram_cmd   <= usr_cmd;
            DRAM_BA    <= usr_ba;
            DRAM_ADDR  <= usr_addr;
            ref_urgent <= (pend_nxt != '0);
          end
        end
        default: begin
          state <= S_WAIT;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
